// File: rtl/ctrl_pipeline.sv
// Control-word carrier for the ID/EX, EX/MEM and MEM/WB stages, with
// load-use stall and jump flush resolution plus saturating debug counters.
module ctrl_pipeline #(
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          id_rd_register_en,
  input  logic          id_wb_enable,
  input  logic          id_rd_mem_en,
  input  logic          id_wr_mem_en,
  input  logic          id_mux_id,
  input  logic          id_mux_exe,
  input  logic          id_mux_mem,
  input  logic          id_jenable,
  input  logic [1:0]    id_alu_op,
  input  logic [RW-1:0] id_rd,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  output logic          ex_valid,
  output logic [1:0]    ex_alu_op,
  output logic          ex_mux_exe,
  output logic          ex_jenable,
  output logic [RW-1:0] ex_rd,
  output logic          mem_valid,
  output logic          mem_rd_mem_en,
  output logic          mem_wr_mem_en,
  output logic          mem_mux_mem,
  output logic [RW-1:0] mem_rd,
  output logic          wb_valid,
  output logic          wb_wb_enable,
  output logic [RW-1:0] wb_rd,
  output logic          stall_id,
  output logic          flush_if,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   flush_cnt
);

  typedef struct packed {
    logic          valid;
    logic          rd_register_en;
    logic          wb_enable;
    logic          rd_mem_en;
    logic          wr_mem_en;
    logic          mux_id;
    logic          mux_exe;
    logic          mux_mem;
    logic          jenable;
    logic [1:0]    alu_op;
    logic [RW-1:0] rd;
  } stage_t;

  stage_t s_ex, s_mem, s_wb;
  stage_t id_word, ex_next;
  logic   stall, flush, load_use;

  // Pack the ID control word; an invalid ID slot is carried as a bubble.
  always_comb begin
    id_word = '0;
    if (id_valid) begin
      id_word.valid          = 1'b1;
      id_word.rd_register_en = id_rd_register_en;
      id_word.wb_enable      = id_wb_enable;
      id_word.rd_mem_en      = id_rd_mem_en;
      id_word.wr_mem_en      = id_wr_mem_en;
      id_word.mux_id         = id_mux_id;
      id_word.mux_exe        = id_mux_exe;
      id_word.mux_mem        = id_mux_mem;
      id_word.jenable        = id_jenable;
      id_word.alu_op         = id_alu_op;
      id_word.rd             = id_rd;
    end else begin
      id_word = '0;
    end
  end

  // Hazard resolution; a jump in EX wins over a load-use dependency.
  always_comb begin
    flush    = s_ex.valid & s_ex.jenable;
    load_use = s_ex.valid & s_ex.rd_mem_en & s_ex.wb_enable & id_valid &
               ((s_ex.rd == id_rs1) | (s_ex.rd == id_rs2));
    stall    = 1'b0;
    ex_next  = id_word;
    if (flush) begin
      ex_next = '0;
    end else if (load_use) begin
      stall   = 1'b1;
      ex_next = '0;
    end else begin
      ex_next = id_word;
    end
  end

  // Stage registers advance every cycle; only ID is ever held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ex  <= '0;
      s_mem <= '0;
      s_wb  <= '0;
    end else begin
      s_ex  <= ex_next;
      s_mem <= s_ex;
      s_wb  <= s_mem;
    end
  end

  // Saturating debug counters for stall and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'h0001;
      end
      if (flush && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'h0001;
      end
    end
  end

  assign stall_id      = stall;
  assign flush_if      = flush;
  assign ex_valid      = s_ex.valid;
  assign ex_alu_op     = s_ex.alu_op;
  assign ex_mux_exe    = s_ex.mux_exe;
  assign ex_jenable    = s_ex.jenable;
  assign ex_rd         = s_ex.rd;
  assign mem_valid     = s_mem.valid;
  assign mem_rd_mem_en = s_mem.rd_mem_en;
  assign mem_wr_mem_en = s_mem.wr_mem_en;
  assign mem_mux_mem   = s_mem.mux_mem;
  assign mem_rd        = s_mem.rd;
  assign wb_valid      = s_wb.valid;
  assign wb_wb_enable  = s_wb.wb_enable;
  assign wb_rd         = s_wb.rd;

  // WB consumers only need valid/wb_enable/rd; the rest ends here.
  logic unused_wb_bits;
  assign unused_wb_bits = ^{s_wb.rd_register_en, s_wb.rd_mem_en, s_wb.wr_mem_en,
                            s_wb.mux_id, s_wb.mux_exe, s_wb.mux_mem,
                            s_wb.jenable, s_wb.alu_op};

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: reset, flow, load-use, jump and counter saturation.
module tb_ctrl_pipeline;
  localparam int RW = 4;
  // Control byte order: {rd_register_en, wb_enable, rd_mem_en, wr_mem_en, mux_id, mux_exe, mux_mem, jenable}
  localparam logic [7:0] ALU   = 8'b1100_0100;
  localparam logic [7:0] LOAD  = 8'b1110_0010;
  localparam logic [7:0] JUMP  = 8'b0000_0001;
  localparam logic [7:0] JLOAD = 8'b1110_0011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid, id_rd_register_en, id_wb_enable, id_rd_mem_en, id_wr_mem_en;
  logic id_mux_id, id_mux_exe, id_mux_mem, id_jenable;
  logic [1:0] id_alu_op;
  logic [RW-1:0] id_rd, id_rs1, id_rs2;
  logic ex_valid, ex_mux_exe, ex_jenable, mem_valid, mem_rd_mem_en, mem_wr_mem_en, mem_mux_mem;
  logic wb_valid, wb_wb_enable, stall_id, flush_if;
  logic [1:0] ex_alu_op;
  logic [RW-1:0] ex_rd, mem_rd, wb_rd;
  logic [15:0] stall_cnt, flush_cnt;
  int pass_cnt = 0;
  int total_cnt = 0;

  ctrl_pipeline #(.RW(RW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rd_register_en(id_rd_register_en), .id_wb_enable(id_wb_enable),
    .id_rd_mem_en(id_rd_mem_en), .id_wr_mem_en(id_wr_mem_en), .id_mux_id(id_mux_id),
    .id_mux_exe(id_mux_exe), .id_mux_mem(id_mux_mem), .id_jenable(id_jenable),
    .id_alu_op(id_alu_op), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_mux_exe(ex_mux_exe),
    .ex_jenable(ex_jenable), .ex_rd(ex_rd), .mem_valid(mem_valid),
    .mem_rd_mem_en(mem_rd_mem_en), .mem_wr_mem_en(mem_wr_mem_en),
    .mem_mux_mem(mem_mux_mem), .mem_rd(mem_rd), .wb_valid(wb_valid),
    .wb_wb_enable(wb_wb_enable), .wb_rd(wb_rd), .stall_id(stall_id),
    .flush_if(flush_if), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [7:0] c, input logic [1:0] op,
                        input logic [RW-1:0] rd, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
    id_valid = v;
    {id_rd_register_en, id_wb_enable, id_rd_mem_en, id_wr_mem_en,
     id_mux_id, id_mux_exe, id_mux_mem, id_jenable} = c;
    id_alu_op = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 8'h00, 2'd0, 4'd0, 4'd0, 4'd0);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    set_id(1'b1, JUMP, 2'd0, 4'd1, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    total_cnt++; if (flush_cnt !== 16'd1) $display("FAIL pre_reset_flush_cnt: got %0d expected 1", flush_cnt); else pass_cnt++;
    total_cnt++; if (ex_jenable !== 1'b1) $display("FAIL pre_reset_ex_jenable: got %0b expected 1", ex_jenable); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (ex_valid !== 1'b0) $display("FAIL rst_ex_valid: got %0b expected 0", ex_valid); else pass_cnt++;
    total_cnt++; if (ex_jenable !== 1'b0) $display("FAIL rst_ex_jenable: got %0b expected 0", ex_jenable); else pass_cnt++;
    total_cnt++; if (ex_rd !== 4'd0) $display("FAIL rst_ex_rd: got %0d expected 0", ex_rd); else pass_cnt++;
    total_cnt++; if (flush_if !== 1'b0) $display("FAIL rst_flush_if: got %0b expected 0", flush_if); else pass_cnt++;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL rst_stall_id: got %0b expected 0", stall_id); else pass_cnt++;
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid: got %0b expected 0", wb_valid); else pass_cnt++;
    total_cnt++; if (flush_cnt !== 16'd0) $display("FAIL rst_flush_cnt: got %0d expected 0", flush_cnt); else pass_cnt++;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) $display("FAIL post_reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); else pass_cnt++;
  endtask

  task automatic test_straight_flow();
    logic [1:0] ops [4];
    ops[0] = 2'd1; ops[1] = 2'd2; ops[2] = 2'd3; ops[3] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, ALU, ops[i], 4'(i + 1), 4'd0, 4'd0);
      #1;
      total_cnt++; if (stall_id !== 1'b0 || flush_if !== 1'b0) $display("FAIL flow_hazard[%0d]: got %0b%0b expected 00", i, stall_id, flush_if); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (ex_alu_op !== ops[i] || ex_valid !== 1'b1) $display("FAIL flow_ex_alu_op[%0d]: got %0d/%0b expected %0d/1", i, ex_alu_op, ex_valid, ops[i]); else pass_cnt++;
      if (i >= 2) begin
        total_cnt++; if (wb_rd !== 4'(i - 1)) $display("FAIL flow_wb_rd[%0d]: got %0d expected %0d", i, wb_rd, i - 1); else pass_cnt++;
      end
    end
    idle(1);
    total_cnt++; if (wb_rd !== 4'd3 || wb_valid !== 1'b1) $display("FAIL flow_wb_rd3: got %0d/%0b expected 3/1", wb_rd, wb_valid); else pass_cnt++;
    idle(1);
    total_cnt++; if (wb_rd !== 4'd4 || wb_wb_enable !== 1'b1) $display("FAIL flow_wb_rd4: got %0d/%0b expected 4/1", wb_rd, wb_wb_enable); else pass_cnt++;
  endtask

  task automatic test_load_use();
    idle(3);
    set_id(1'b1, LOAD, 2'd0, 4'd5, 4'd0, 4'd0);
    @(negedge clk);
    set_id(1'b1, ALU, 2'd2, 4'd6, 4'd5, 4'd0);
    #1;
    total_cnt++; if (stall_id !== 1'b1 || flush_if !== 1'b0) $display("FAIL lu_stall: got %0b%0b expected 10", stall_id, flush_if); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ex_valid !== 1'b0) $display("FAIL lu_ex_bubble: got %0b expected 0", ex_valid); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); else pass_cnt++;
    total_cnt++; if (mem_rd_mem_en !== 1'b1 || mem_mux_mem !== 1'b1 || mem_rd !== 4'd5) $display("FAIL lu_mem_view: got %0b%0b rd%0d expected 11 rd5", mem_rd_mem_en, mem_mux_mem, mem_rd); else pass_cnt++;
    #1;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL lu_stall_clear: got %0b expected 0", stall_id); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ex_valid !== 1'b1 || ex_rd !== 4'd6 || ex_mux_exe !== 1'b1) $display("FAIL lu_dep_in_ex: got v%0b rd%0d mx%0b expected v1 rd6 mx1", ex_valid, ex_rd, ex_mux_exe); else pass_cnt++;
    total_cnt++; if (mem_valid !== 1'b0 || wb_rd !== 4'd5 || wb_wb_enable !== 1'b1) $display("FAIL lu_tail: got mv%0b wbrd%0d wbe%0b expected 0 5 1", mem_valid, wb_rd, wb_wb_enable); else pass_cnt++;
  endtask

  task automatic test_no_false_stall();
    idle(3);
    set_id(1'b1, LOAD, 2'd0, 4'd5, 4'd0, 4'd0);
    @(negedge clk);
    set_id(1'b1, ALU, 2'd1, 4'd8, 4'd6, 4'd7);
    #1;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL nfs_stall: got %0b expected 0", stall_id); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ex_valid !== 1'b1 || ex_rd !== 4'd8 || stall_cnt !== 16'd1) $display("FAIL nfs_ex: got v%0b rd%0d cnt%0d expected v1 rd8 cnt1", ex_valid, ex_rd, stall_cnt); else pass_cnt++;
    idle(3);
    set_id(1'b1, LOAD, 2'd0, 4'd5, 4'd0, 4'd0);
    @(negedge clk);
    set_id(1'b1, ALU, 2'd1, 4'd9, 4'd1, 4'd5);
    #1;
    total_cnt++; if (stall_id !== 1'b1) $display("FAIL rs2_stall: got %0b expected 1", stall_id); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (stall_cnt !== 16'd2) $display("FAIL rs2_stall_cnt: got %0d expected 2", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_invalid_id();
    idle(3);
    set_id(1'b0, JLOAD, 2'd3, 4'd7, 4'd0, 4'd0);
    @(negedge clk);
    total_cnt++; if (ex_valid !== 1'b0 || ex_alu_op !== 2'd0 || ex_rd !== 4'd0 || ex_jenable !== 1'b0) $display("FAIL inv_ex: got v%0b op%0d rd%0d j%0b expected all 0", ex_valid, ex_alu_op, ex_rd, ex_jenable); else pass_cnt++;
    #1;
    total_cnt++; if (flush_if !== 1'b0) $display("FAIL inv_flush: got %0b expected 0", flush_if); else pass_cnt++;
  endtask

  task automatic test_jump();
    idle(3);
    set_id(1'b1, JLOAD, 2'd0, 4'd5, 4'd0, 4'd0);
    @(negedge clk);
    set_id(1'b1, ALU, 2'd1, 4'd9, 4'd5, 4'd0);
    #1;
    total_cnt++; if (flush_if !== 1'b1 || stall_id !== 1'b0) $display("FAIL jmp_hazard: got f%0b s%0b expected f1 s0", flush_if, stall_id); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ex_valid !== 1'b0) $display("FAIL jmp_ex_bubble: got %0b expected 0", ex_valid); else pass_cnt++;
    total_cnt++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) $display("FAIL jmp_cnts: got f%0d s%0d expected f1 s2", flush_cnt, stall_cnt); else pass_cnt++;
    set_id(1'b1, ALU, 2'd2, 4'd10, 4'd0, 4'd0);
    #1;
    total_cnt++; if (flush_if !== 1'b0) $display("FAIL jmp_one_cycle: got %0b expected 0", flush_if); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ex_valid !== 1'b1 || ex_rd !== 4'd10) $display("FAIL jmp_resume: got v%0b rd%0d expected v1 rd10", ex_valid, ex_rd); else pass_cnt++;
  endtask

  task automatic test_saturation();
    idle(3);
    force dut.stall_cnt = 16'hFFFB;
    #1 release dut.stall_cnt;
    set_id(1'b1, LOAD, 2'd0, 4'd5, 4'd5, 4'd0);
    repeat (4) @(negedge clk);
    total_cnt++; if (stall_cnt !== 16'hFFFD) $display("FAIL sat_mid: got %h expected fffd", stall_cnt); else pass_cnt++;
    repeat (12) @(negedge clk);
    total_cnt++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_top: got %h expected ffff", stall_cnt); else pass_cnt++;
    repeat (6) @(negedge clk);
    total_cnt++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", stall_cnt); else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_id(1'b0, 8'h00, 2'd0, 4'd0, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_straight_flow();
    test_load_use();
    test_no_false_stall();
    test_invalid_id();
    test_jump();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
